// File: rtl/enoc_node_interface_pkg.sv
// Shared types for the ENoC node interface: packet layout, field widths, saturating counter helper.
package enoc_node_interface_pkg;

    localparam int NODES_DEF    = 16;
    localparam int ID_W         = $clog2(NODES_DEF);
    localparam int TS_WIDTH_DEF = 16;
    localparam int PAYLOAD_W    = 32;

    typedef struct packed {
        logic                    measure;
        logic [TS_WIDTH_DEF-1:0] timestamp;
        logic [ID_W-1:0]         source;
        logic [ID_W-1:0]         dest;
        logic [PAYLOAD_W-1:0]    payload;
    } packet_t;

    // Holds at max_v instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/enoc_inject_fifo.sv
// Injection FIFO: registered storage, head valid the cycle after the first push (no fall-through).
// Latency 1 cycle push-to-head; the caller must gate push with full/pop, full is a registered flag.
// Backpressure: none internally; pop is only honoured by the caller while not empty.
module enoc_inject_fifo
    import enoc_node_interface_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  packet_t push_data,
    input  logic    pop,
    output packet_t head,
    output logic    empty,
    output logic    full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    packet_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            full_q, full_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Stale RAM contents are masked so an empty queue always presents zero.
    assign empty = (cnt_q == '0);
    assign full  = full_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/enoc_node_interface.sv
// Node interface: stamps and queues source packets for the network, registers ejected packets to the sink.
// Latency: push to o_net_data_val 1 cycle; ejection to o_sink_val 1 cycle. LATENCY_MEASURE_EN adds o_lat/o_lat_val/o_lat_max.
// Backpressure: i_net_en stalls injection, full FIFO drops source packets; ejection never stalls (o_net_en=1).
module enoc_node_interface
    import enoc_node_interface_pkg::*;
#(
    parameter int NODE_ID    = 0,
    parameter int NODES      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  packet_t              i_src_data,
    input  logic                 i_src_val,
    output logic                 o_src_full,
    output packet_t              o_net_data,
    output logic                 o_net_data_val,
    input  logic                 i_net_en,
    input  packet_t              i_net_data,
    input  logic                 i_net_data_val,
    output logic                 o_net_en,
    output packet_t              o_sink_data,
    output logic                 o_sink_val,
    output logic [CNT_WIDTH-1:0] o_tx_count,
    output logic [CNT_WIDTH-1:0] o_rx_count,
    output logic [CNT_WIDTH-1:0] o_drop_count,
    output logic                 o_misroute
`ifdef LATENCY_MEASURE_EN
    ,
    output logic [TS_WIDTH-1:0]  o_lat,
    output logic                 o_lat_val,
    output logic [TS_WIDTH-1:0]  o_lat_max
`endif
);

    localparam int NODE_ID_W = $clog2(NODES);
    localparam logic [NODE_ID_W-1:0] NODE_ID_C = NODE_ID_W'(NODE_ID);
    localparam logic [63:0] CNT_MAX = {{(64-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

    packet_t                fifo_head, push_entry;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop, drop, eject;
    logic [TS_WIDTH-1:0]    cycle_q, cycle_d;
    logic                   net_en_q, net_en_d;
    logic                   sink_val_q, sink_val_d;
    packet_t                sink_data_q, sink_data_d;
    logic [CNT_WIDTH-1:0]   tx_q, tx_d, rx_q, rx_d, drop_q, drop_d;
    logic                   misroute_q, misroute_d;
`ifdef LATENCY_MEASURE_EN
    logic [TS_WIDTH-1:0]    lat_q, lat_d, lat_max_q, lat_max_d;
    logic                   lat_val_q, lat_val_d;
`endif

    always_comb begin
        pop        = !fifo_empty && i_net_en;
        push       = i_src_val && (!fifo_full || pop);
        drop       = i_src_val && fifo_full && !pop;
        eject      = i_net_data_val && net_en_q;

        push_entry           = i_src_data;
        push_entry.source    = ID_W'(NODE_ID_C);
        push_entry.timestamp = TS_WIDTH_DEF'(cycle_q);

        cycle_d     = cycle_q + 1'b1;
        net_en_d    = 1'b1;
        sink_val_d  = eject;
        sink_data_d = eject ? i_net_data : sink_data_q;
        tx_d        = pop   ? CNT_WIDTH'(sat_inc(64'(tx_q), CNT_MAX))   : tx_q;
        rx_d        = eject ? CNT_WIDTH'(sat_inc(64'(rx_q), CNT_MAX))   : rx_q;
        drop_d      = drop  ? CNT_WIDTH'(sat_inc(64'(drop_q), CNT_MAX)) : drop_q;
        misroute_d  = misroute_q | (eject && (i_net_data.dest != ID_W'(NODE_ID_C)));
`ifdef LATENCY_MEASURE_EN
        lat_d       = eject ? cycle_q - TS_WIDTH'(i_net_data.timestamp) : lat_q;
        lat_val_d   = eject;
        lat_max_d   = (eject && (lat_d > lat_max_q)) ? lat_d : lat_max_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q     <= '0;
            net_en_q    <= 1'b0;
            sink_val_q  <= 1'b0;
            sink_data_q <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            drop_q      <= '0;
            misroute_q  <= 1'b0;
`ifdef LATENCY_MEASURE_EN
            lat_q       <= '0;
            lat_val_q   <= 1'b0;
            lat_max_q   <= '0;
`endif
        end else begin
            cycle_q     <= cycle_d;
            net_en_q    <= net_en_d;
            sink_val_q  <= sink_val_d;
            sink_data_q <= sink_data_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            drop_q      <= drop_d;
            misroute_q  <= misroute_d;
`ifdef LATENCY_MEASURE_EN
            lat_q       <= lat_d;
            lat_val_q   <= lat_val_d;
            lat_max_q   <= lat_max_d;
`endif
        end
    end

    enoc_inject_fifo #(.DEPTH(FIFO_DEPTH)) u_inject_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign o_src_full     = fifo_full;
    assign o_net_data     = fifo_head;
    assign o_net_data_val = !fifo_empty;
    assign o_net_en       = net_en_q;
    assign o_sink_val     = sink_val_q;
    assign o_sink_data    = sink_data_q;
    assign o_tx_count     = tx_q;
    assign o_rx_count     = rx_q;
    assign o_drop_count   = drop_q;
    assign o_misroute     = misroute_q;
`ifdef LATENCY_MEASURE_EN
    assign o_lat          = lat_q;
    assign o_lat_val      = lat_val_q;
    assign o_lat_max      = lat_max_q;
`endif

endmodule

// File: tb/tb_enoc_node_interface.sv
// Bench for enoc_node_interface: fill/drop vector table, directed corner sequences, random traffic vs a queue model.
module tb_enoc_node_interface;
    import enoc_node_interface_pkg::*;

    localparam int NID   = 5;
    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    packet_t       i_src_data = '0;
    logic          i_src_val = 1'b0;
    logic          o_src_full;
    packet_t       o_net_data;
    logic          o_net_data_val;
    logic          i_net_en = 1'b0;
    packet_t       i_net_data = '0;
    logic          i_net_data_val = 1'b0;
    logic          o_net_en;
    packet_t       o_sink_data;
    logic          o_sink_val;
    logic [CW-1:0] o_tx_count, o_rx_count, o_drop_count;
    logic          o_misroute;
`ifdef LATENCY_MEASURE_EN
    logic [15:0]   o_lat, o_lat_max;
    logic          o_lat_val;
`endif

    always #5 clk = ~clk;

    enoc_node_interface #(
        .NODE_ID(NID), .NODES(16), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_src_data(i_src_data), .i_src_val(i_src_val), .o_src_full(o_src_full),
        .o_net_data(o_net_data), .o_net_data_val(o_net_data_val), .i_net_en(i_net_en),
        .i_net_data(i_net_data), .i_net_data_val(i_net_data_val), .o_net_en(o_net_en),
        .o_sink_data(o_sink_data), .o_sink_val(o_sink_val),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_drop_count(o_drop_count),
        .o_misroute(o_misroute)
`ifdef LATENCY_MEASURE_EN
        , .o_lat(o_lat), .o_lat_val(o_lat_val), .o_lat_max(o_lat_max)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    packet_t       mq[$];
    logic [15:0]   m_cyc;
    logic [CW-1:0] m_tx, m_rx, m_drop;
    logic          m_mis, m_en, m_sink_val;
    packet_t       m_sink_data;
    logic [15:0]   m_lat, m_lat_max;

    typedef struct {
        logic        sv;
        logic        ne;
        logic [31:0] pl;
        logic        exp_val;
        logic        exp_full;
        int          exp_drop;
        int          exp_tx;
        logic        chk_pl;
        logic [31:0] exp_pl;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cyc = 0; m_tx = 0; m_rx = 0; m_drop = 0;
        m_mis = 0; m_en = 0; m_sink_val = 0; m_sink_data = '0;
        m_lat = 0; m_lat_max = 0;
    endtask

    task automatic model_edge(input logic sv, input packet_t sd, input logic ne,
                              input logic nv, input packet_t nd);
        packet_t p;
        bit was_full, do_pop, do_push, ej;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && ne;
        do_push  = sv && (!was_full || do_pop);
        if (do_pop) begin
            void'(mq.pop_front());
            m_tx = sat(m_tx);
        end
        if (do_push) begin
            p = sd; p.source = NID[3:0]; p.timestamp = m_cyc;
            mq.push_back(p);
        end
        if (sv && !do_push) m_drop = sat(m_drop);
        ej = nv && m_en;
        m_sink_val = ej;
        if (ej) begin
            m_sink_data = nd;
            m_rx = sat(m_rx);
            if (nd.dest != NID[3:0]) m_mis = 1'b1;
            m_lat = m_cyc - nd.timestamp;
            if (m_lat > m_lat_max) m_lat_max = m_lat;
        end
        m_en  = 1'b1;
        m_cyc = m_cyc + 16'd1;
    endtask

    task automatic check_all();
        chk("net_val", o_net_data_val, mq.size() != 0);
        if (mq.size() != 0) chk("net_data", o_net_data, mq[0]);
        chk("src_full", o_src_full, mq.size() == DEPTH);
        chk("tx_count", o_tx_count, m_tx);
        chk("drop_count", o_drop_count, m_drop);
        chk("rx_count", o_rx_count, m_rx);
        chk("sink_val", o_sink_val, m_sink_val);
        if (m_sink_val) chk("sink_data", o_sink_data, m_sink_data);
        chk("misroute", o_misroute, m_mis);
        chk("net_en", o_net_en, m_en);
`ifdef LATENCY_MEASURE_EN
        chk("lat_val", o_lat_val, m_sink_val);
        if (m_sink_val) chk("lat", o_lat, m_lat);
        chk("lat_max", o_lat_max, m_lat_max);
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input logic sv, input packet_t sd, input logic ne,
                        input logic nv, input packet_t nd);
        i_src_val = sv; i_src_data = sd; i_net_en = ne;
        i_net_data_val = nv; i_net_data = nd;
        @(posedge clk);
        model_edge(sv, sd, ne, nv, nd);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic ne);
        step(1'b0, '0, ne, 1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_val"}, o_net_data_val, 0);
        chk({tag, "_data"}, o_net_data, 0);
        chk({tag, "_full"}, o_src_full, 0);
        chk({tag, "_sink_val"}, o_sink_val, 0);
        chk({tag, "_sink_data"}, o_sink_data, 0);
        chk({tag, "_mis"}, o_misroute, 0);
        chk({tag, "_net_en"}, o_net_en, 0);
        chk({tag, "_tx"}, o_tx_count, 0);
        chk({tag, "_rx"}, o_rx_count, 0);
        chk({tag, "_drop"}, o_drop_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_src_val = 0; i_net_en = 0; i_net_data_val = 0; i_src_data = '0; i_net_data = '0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic packet_t mk_pkt(input int dest, input logic [31:0] pl);
        packet_t p;
        p = '0;
        p.dest = dest[3:0];
        p.payload = pl;
        return p;
    endfunction

    function automatic packet_t rnd_pkt();
        packet_t p;
        p.measure   = 1'($urandom_range(1, 0));
        p.timestamp = 16'($urandom);
        p.source    = 4'($urandom_range(15, 0));
        p.dest      = ($urandom_range(3, 0) != 0) ? NID[3:0] : 4'($urandom_range(15, 0));
        p.payload   = $urandom;
        return p;
    endfunction

    initial begin
        packet_t p;

        // sv ne pl   | val full drop tx | chk_pl exp_pl
        tbl[0]  = '{1, 0, 100, 1, 0, 0, 0, 1, 100};
        tbl[1]  = '{1, 0, 101, 1, 0, 0, 0, 1, 100};
        tbl[2]  = '{1, 0, 102, 1, 0, 0, 0, 1, 100};
        tbl[3]  = '{1, 0, 103, 1, 0, 0, 0, 1, 100};
        tbl[4]  = '{1, 0, 104, 1, 0, 0, 0, 1, 100};
        tbl[5]  = '{1, 0, 105, 1, 0, 0, 0, 1, 100};
        tbl[6]  = '{1, 0, 106, 1, 0, 0, 0, 1, 100};
        tbl[7]  = '{1, 0, 107, 1, 1, 0, 0, 1, 100};
        tbl[8]  = '{1, 0, 108, 1, 1, 1, 0, 1, 100};
        tbl[9]  = '{1, 0, 109, 1, 1, 2, 0, 1, 100};
        tbl[10] = '{0, 1, 0,   1, 0, 2, 1, 1, 101};
        tbl[11] = '{0, 1, 0,   1, 0, 2, 2, 1, 102};
        tbl[12] = '{0, 1, 0,   1, 0, 2, 3, 1, 103};
        tbl[13] = '{0, 1, 0,   1, 0, 2, 4, 1, 104};
        tbl[14] = '{0, 1, 0,   1, 0, 2, 5, 1, 105};
        tbl[15] = '{0, 1, 0,   1, 0, 2, 6, 1, 106};
        tbl[16] = '{0, 1, 0,   1, 0, 2, 7, 1, 107};
        tbl[17] = '{0, 1, 0,   0, 0, 2, 8, 0, 0};

        do_reset();
        for (int k = 0; k < 18; k++) begin
            i_src_val = tbl[k].sv; i_src_data = mk_pkt(NID, tbl[k].pl);
            i_net_en = tbl[k].ne; i_net_data_val = 0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_val", k), o_net_data_val, tbl[k].exp_val);
            chk($sformatf("tbl%0d_full", k), o_src_full, tbl[k].exp_full);
            chk($sformatf("tbl%0d_drop", k), o_drop_count, tbl[k].exp_drop);
            chk($sformatf("tbl%0d_tx", k), o_tx_count, tbl[k].exp_tx);
            if (tbl[k].chk_pl) chk($sformatf("tbl%0d_head", k), o_net_data.payload, tbl[k].exp_pl);
        end

        // Single packet: pushed at cycle 10, stamped with source and time
        do_reset();
        while (m_cyc != 16'd10) idle(1'b1);
        step(1'b1, mk_pkt(3, 32'hABCD), 1'b1, 1'b0, '0);
        chk("single_val", o_net_data_val, 1);
        chk("single_src", o_net_data.source, NID);
        chk("single_ts", o_net_data.timestamp, 10);
        chk("single_dest", o_net_data.dest, 3);
        idle(1'b1);
        chk("single_tx", o_tx_count, 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int k = 0; k < DEPTH; k++) step(1'b1, mk_pkt(1, 32'(200 + k)), 1'b0, 1'b0, '0);
        chk("full_set", o_src_full, 1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, mk_pkt(1, 32'(300 + k)), 1'b1, 1'b0, '0);
            chk("full_pp_full", o_src_full, 1);
            chk("full_pp_head", o_net_data.payload, 201 + k);
        end
        chk("full_pp_drop", o_drop_count, 0);
        for (int k = 0; k < DEPTH + 1; k++) idle(1'b1);

        // Back-to-back ejection, second one misrouted
        step(1'b0, '0, 1'b0, 1'b1, mk_pkt(NID, 32'h55));
        chk("ej1_sink_val", o_sink_val, 1);
        chk("ej1_mis", o_misroute, 0);
        step(1'b0, '0, 1'b0, 1'b1, mk_pkt(7, 32'h77));
        chk("ej2_sink_val", o_sink_val, 1);
        chk("ej2_rx", o_rx_count, 2);
        chk("ej2_mis", o_misroute, 1);
        idle(1'b0);
        chk("ej_pulse_end", o_sink_val, 0);
        chk("ej_mis_sticky", o_misroute, 1);

        // Reset between edges with packets queued
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, mk_pkt(2, 32'(400 + k)), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b1, mk_pkt(9, 32'h9));
        #2;
        reset_n = 1'b0;
        i_src_val = 0; i_net_en = 0; i_net_data_val = 0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) idle(1'b1);
        chk("midrst_tx_after", o_tx_count, 0);

        // Randomised traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(9, 0) < 6), rnd_pkt(), 1'($urandom_range(1, 0)),
                 1'($urandom_range(9, 0) < 4), rnd_pkt());
        end

        // Drop counter saturation
        do_reset();
        for (int k = 0; k < 270; k++) step(1'b1, rnd_pkt(), 1'b0, 1'b0, '0);
        chk("drop_sat", o_drop_count, 255);

`ifdef LATENCY_MEASURE_EN
        do_reset();
        while (m_cyc != 16'd4) idle(1'b0);
        p = mk_pkt(NID, 32'h1);
        p.timestamp = 16'd65530;
        step(1'b0, '0, 1'b0, 1'b1, p);
        chk("lat_wrap", o_lat, 10);
        chk("lat_max_wrap", o_lat_max, 10);
`else
        p = '0;
        i_src_data = p;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enoc_node_interface.md
Name: enoc_node_interface

Overview:
Per-node network interface between a node's traffic source/sink and one local port of the ENoC mesh/torus network.
- Injection side: buffers source packets in an injection FIFO and stamps each with source ID and injection time. Presents packets to the network local input using the valid/enable protocol.
- Ejection side: accepts packets from the network local output, registers them to the sink, checks the destination, and keeps tx/rx/drop statistics.
- One instance per node, between the traffic generator and the network.

Parameters:
NODE_ID, 0, this node's number (router number in the network)
NODES, 16, total nodes; sets ID field width
FIFO_DEPTH, 8, injection FIFO entries (power of 2, >=2)
TS_WIDTH, 16, timestamp / cycle counter width
CNT_WIDTH, 32, statistics counter width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_src_data  input  packet_t  packet from traffic source; dest and payload fields are used
i_src_val  input  1  source packet valid this cycle
o_src_full  output  1  injection FIFO full (advisory; source may still drive val)
o_net_data  output  packet_t  to network local input
o_net_data_val  output  1  o_net_data valid
i_net_en  input  1  network accepts o_net_data this cycle
i_net_data  input  packet_t  from network local output
i_net_data_val  input  1  i_net_data valid
o_net_en  output  1  enables network to send to this node
o_sink_data  output  packet_t  ejected packet
o_sink_val  output  1  ejected packet valid (one-cycle pulse per packet)
o_tx_count  output  CNT_WIDTH  packets accepted by network
o_rx_count  output  CNT_WIDTH  packets ejected
o_drop_count  output  CNT_WIDTH  source packets dropped (FIFO full)
o_misroute  output  1  sticky: a packet was ejected with dest != NODE_ID

Behaviour:
- Reset (async, reset_n=0): FIFO pointers and occupancy cleared, cycle counter 0, all counters 0.
- Reset values: o_src_full=0, o_net_data_val=0, o_net_data=0, o_sink_val=0, o_sink_data=0, o_misroute=0, o_net_en=0.
- Reset asserted mid-operation: FIFO contents are discarded, counters clear, and no packet is reported as transmitted.
- Cycle counter: free-running TS_WIDTH bits, +1 every cycle, wraps modulo 2^TS_WIDTH.
- Transfer rule: a transfer occurs on a cycle where valid=1 and enable=1 at the clock edge.
- Push: i_src_val=1 and (not full, or pop in the same cycle).
  - Stored entry = i_src_data with source:=NODE_ID and timestamp:=cycle counter value of that cycle.
- Drop: i_src_val=1, FIFO full and no pop that cycle. Packet is discarded and o_drop_count increments.
- Pop: o_net_data_val && i_net_en. o_tx_count increments.
- Head presentation: o_net_data_val = FIFO not empty. o_net_data = head entry.
  - Head and valid are held stable until popped.
- Latency: empty FIFO, push at cycle N -> o_net_data_val=1 at cycle N+1; there is no fall-through.
- Simultaneous push+pop:
  - When full: occupancy unchanged, no drop.
  - When empty: the push only; pop cannot occur since val=0.
- o_src_full = (occupancy == FIFO_DEPTH), registered.
- Pointer wrap: log2(FIFO_DEPTH) bit pointers wrap naturally. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Ejection: o_net_en=1 every cycle after reset (the sink never stalls).
  - On i_net_data_val && o_net_en: register into o_sink_data, pulse o_sink_val next cycle, o_rx_count increments.
  - Back-to-back ejection gives o_sink_val high on consecutive cycles.
- Misroute: ejected packet dest != NODE_ID sets o_misroute=1 until reset. The packet is still delivered and counted.
- Counters: saturate at all-ones and never wrap.

Optional Feature:
LATENCY_MEASURE_EN
- Defined:
  - Extra outputs o_lat (TS_WIDTH) and o_lat_val (1).
  - On each ejection, o_lat = (cycle counter at ejection - packet timestamp) mod 2^TS_WIDTH, with o_lat_val aligned to o_sink_val.
  - Adds o_lat_max (TS_WIDTH): running maximum, cleared on reset.
- Undefined: none of these ports or logic exist. The timestamp field is still written on injection.

Decomposition:
- Shared package: packet_t (payload, dest, source, timestamp, measure flag), ID width = $clog2(NODES), TS_WIDTH default, and a saturating-increment function.
- Natural sub-module: enoc_inject_fifo, a synchronous FIFO with push/pop/full/empty/occupancy parameterised by packet_t and FIFO_DEPTH.
- Ejection path and counters stay in the top module.

Test Plan:
- Single packet: reset, NODE_ID=5, push dest=3 at cycle 10, i_net_en=1 -> o_net_data_val=1 at cycle 11; source=5, timestamp=10; o_tx_count=1 at cycle 12.
- Fill and drop: i_net_en=0, push 10 packets into FIFO_DEPTH=8 -> o_src_full=1 after the 8th push, o_drop_count=2; then i_net_en=1 -> 8 packets out in FIFO order, o_tx_count=8.
- Full push+pop: FIFO full, i_src_val=1 and i_net_en=1 for 4 cycles -> no drops, o_src_full stays 1, output order preserved.
- Ejection/misroute: NODE_ID=5, inject dest=5 then dest=7 back-to-back -> o_sink_val for 2 cycles, o_rx_count=2, o_misroute=1 after the second.
- Reset mid-operation: 3 packets queued, pulse reset_n low between edges -> outputs clear immediately, o_net_data_val=0, counters 0; the old packets never appear.
- LATENCY_MEASURE_EN: ejected packet with timestamp=65530, ejection cycle counter=4 (wrapped) -> o_lat=10, o_lat_max=10.
